// File: rtl/hybrid_session_ctrl.sv
// Hybrid decrypt session controller: takes an RSA-wrapped AES key and N ciphertext
// blocks, drives the external RSA/AES decrypt cores and streams plaintext bytes out.
module hybrid_session_ctrl #(
   parameter int TIMEOUT_CYC = 100000,
   parameter int KEY_W       = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rsa_start,
   output logic [KEY_W-1:0] rsa_cipher,
   input  logic             rsa_done,
   input  logic [KEY_W-1:0] rsa_result,
   output logic             aes_start,
   output logic [KEY_W-1:0] aes_key,
   output logic [KEY_W-1:0] aes_block,
   input  logic             aes_done,
   input  logic [KEY_W-1:0] aes_result,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             session_done,
   output logic [7:0]       blocks_done,
   output logic             err_overrun,
   output logic             err_timeout
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {RX_KEY, RX_CNT, RX_BLK, RX_END} rx_t;
   typedef enum logic [2:0] {S_IDLE, S_RSA, S_WAIT_BLK, S_AES, S_TX} core_t;

   rx_t              rx_q, rx_d;
   core_t            st_q, st_d;
   logic [3:0]       byte_cnt, tx_cnt;
   logic [7:0]       n_blk, blk_rcvd;
   logic [KEY_W-1:0] blk_buf, tx_sr;
   logic             blk_full, rsa_ok;
   logic [TW-1:0]    tmo_cnt;

   logic tx_hs, tx_last, copy, cnt_known, rsa_fin, sess_end;
   logic key_take, cnt_take, blk_take, take, key_last, blk_last;
   logic overrun, tmo_run, tmo_fire;

   always_comb begin
      tx_hs     = (st_q == S_TX) && tx_ready;
      tx_last   = tx_hs && (tx_cnt == 4'd15);
      copy      = (st_q == S_WAIT_BLK) && blk_full;
      // the count byte may trail the RSA result; hold S_RSA until N is known
      cnt_known = (rx_q == RX_BLK) || (rx_q == RX_END);
      rsa_fin   = (st_q == S_RSA) && (rsa_done || rsa_ok) && cnt_known;
      sess_end  = (rsa_fin && (n_blk == 8'd0)) ||
                  (tx_last && ((blocks_done + 8'd1) == n_blk));
      key_take  = rx_valid && (rx_q == RX_KEY) && (st_q == S_IDLE);
      cnt_take  = rx_valid && (rx_q == RX_CNT);
      // a byte landing on the copy cycle goes into the buffer being vacated
      blk_take  = rx_valid && (rx_q == RX_BLK) && (!blk_full || copy);
      overrun   = rx_valid && (((rx_q == RX_BLK) && blk_full && !copy) || (rx_q == RX_END));
      take      = key_take || cnt_take || blk_take;
      key_last  = key_take && (byte_cnt == 4'd15);
      blk_last  = blk_take && (byte_cnt == 4'd15);
      tmo_run   = ((rx_q == RX_KEY) && (byte_cnt != 4'd0)) || (rx_q == RX_CNT) ||
                  ((rx_q == RX_BLK) && !blk_full);
      tmo_fire  = tmo_run && !take && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= S_IDLE;
         rx_q <= RX_KEY;
      end else begin
         st_q <= st_d;
         rx_q <= rx_d;
      end
   end

   always_comb begin
      st_d = st_q;
      if (tmo_fire) st_d = S_IDLE;
      else begin
         case (st_q)
            S_IDLE:     if (key_last) st_d = S_RSA;
            S_RSA:      if (rsa_fin) st_d = (n_blk == 8'd0) ? S_IDLE : S_WAIT_BLK;
            S_WAIT_BLK: if (blk_full) st_d = S_AES;
            S_AES:      if (aes_done) st_d = S_TX;
            S_TX:       if (tx_last) st_d = sess_end ? S_IDLE : S_WAIT_BLK;
            default:    st_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_d = rx_q;
      if (tmo_fire || sess_end) rx_d = RX_KEY;
      else begin
         case (rx_q)
            RX_KEY:  if (key_last) rx_d = RX_CNT;
            RX_CNT:  if (cnt_take) rx_d = (rx_data == 8'd0) ? RX_END : RX_BLK;
            RX_BLK:  if (blk_last && ((blk_rcvd + 8'd1) == n_blk)) rx_d = RX_END;
            default: rx_d = rx_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsa_start    <= 1'b0;
         aes_start    <= 1'b0;
         session_done <= 1'b0;
         err_overrun  <= 1'b0;
         err_timeout  <= 1'b0;
         rsa_cipher   <= '0;
         aes_key      <= '0;
         aes_block    <= '0;
         blk_buf      <= '0;
         tx_sr        <= '0;
         tx_cnt       <= 4'd0;
         byte_cnt     <= 4'd0;
         n_blk        <= 8'd0;
         blk_rcvd     <= 8'd0;
         blocks_done  <= 8'd0;
         blk_full     <= 1'b0;
         rsa_ok       <= 1'b0;
         tmo_cnt      <= '0;
      end else begin
         rsa_start    <= key_last;
         aes_start    <= copy && !tmo_fire;
         session_done <= sess_end;
         if (overrun)  err_overrun <= 1'b1;
         if (tmo_fire) err_timeout <= 1'b1;
         if (key_take) rsa_cipher <= {rsa_cipher[KEY_W-9:0], rx_data};
         if (cnt_take) n_blk <= rx_data;
         if (blk_take) blk_buf <= {blk_buf[KEY_W-9:0], rx_data};
         if (copy)     aes_block <= blk_buf;
         if ((st_q == S_RSA) && rsa_done) aes_key <= rsa_result;
         rsa_ok <= (st_q == S_RSA) && (st_d == S_RSA) && (rsa_ok || rsa_done);

         if ((st_q == S_AES) && aes_done) begin
            tx_sr  <= aes_result;
            tx_cnt <= 4'd0;
         end else if (tx_hs) begin
            tx_sr  <= tx_sr << 8;
            tx_cnt <= tx_cnt + 4'd1;
         end

         if (tmo_fire || sess_end)     byte_cnt <= 4'd0;
         else if (key_take || blk_take) byte_cnt <= byte_cnt + 4'd1;

         if (tmo_fire || (key_take && (byte_cnt == 4'd0))) blocks_done <= 8'd0;
         else if (tx_last)                                 blocks_done <= blocks_done + 8'd1;

         if (tmo_fire || cnt_take) blk_rcvd <= 8'd0;
         else if (blk_last)        blk_rcvd <= blk_rcvd + 8'd1;

         if (tmo_fire) blk_full <= 1'b0;
         else          blk_full <= (blk_full && !copy) || blk_last;

         if (take || tmo_fire) tmo_cnt <= '0;
         else if (tmo_run)     tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tx_valid = (st_q == S_TX);
   assign tx_data  = tx_sr[KEY_W-1 -: 8];
   assign busy     = (st_q != S_IDLE) || (rx_q != RX_KEY) || (byte_cnt != 4'd0);

endmodule

// File: tb/tb_hybrid_session_ctrl.sv
// Directed bench for hybrid_session_ctrl with RSA identity stub and AES known-answer/xor stub.
module tb_hybrid_session_ctrl;
   localparam int TMO = 50;
   localparam logic [127:0] K  = 128'h12345678987654321234567898765432;
   localparam logic [127:0] B  = 128'h08938A533D49A4F5DD8C42A3717876DA;
   localparam logic [127:0] PT = 128'hABCDEF01020304050607080900000000;
   localparam logic [127:0] K2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
   localparam logic [127:0] C0 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] C1 = 128'hFEDCBA98765432100123456789ABCDEF;
   localparam logic [127:0] C2 = 128'h5A5A5A5AA5A5A5A50000FFFF1234ABCD;

   logic         clk = 1'b0, rst = 1'b1;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rsa_start, rsa_done, aes_start, aes_done;
   logic [127:0] rsa_cipher, rsa_result, aes_key, aes_block, aes_result;
   logic [7:0]   tx_data, blocks_done;
   logic         tx_valid, tx_ready, busy, session_done, err_overrun, err_timeout;

   int n_cmp = 0, n_bad = 0;
   int rsa_lat = 10, aes_lat = 5;
   logic stall = 1'b0;
   int cyc = 0, n_rsa = 0, n_aes = 0, n_sd = 0, n_txv = 0, rd_cyc = 0, sd_cyc = 0;
   logic [7:0]   txq[$];
   logic [7:0]   fq[$];
   logic [127:0] rsa_cap, aes_cap;

   hybrid_session_ctrl #(.TIMEOUT_CYC(TMO), .KEY_W(128)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rsa_start(rsa_start), .rsa_cipher(rsa_cipher), .rsa_done(rsa_done), .rsa_result(rsa_result),
      .aes_start(aes_start), .aes_key(aes_key), .aes_block(aes_block), .aes_done(aes_done),
      .aes_result(aes_result), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .session_done(session_done), .blocks_done(blocks_done),
      .err_overrun(err_overrun), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rsa_start) n_rsa++;
      if (aes_start) n_aes++;
      if (rsa_done) rd_cyc = cyc;
      if (session_done) begin n_sd++; sd_cyc = cyc; end
      if (tx_valid) n_txv++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
   end

   // identity RSA core
   initial begin
      rsa_done = 1'b0; rsa_result = '0;
      forever begin
         @(negedge clk);
         if (rsa_start) begin
            rsa_cap = rsa_cipher;
            repeat (rsa_lat) @(posedge clk);
            #1 rsa_done = 1'b1; rsa_result = rsa_cap;
            @(posedge clk);
            #1 rsa_done = 1'b0;
         end
      end
   end

   // AES core: known-answer pair for K/B, otherwise block xor key
   initial begin
      aes_done = 1'b0; aes_result = '0;
      forever begin
         @(negedge clk);
         if (aes_start) begin
            aes_cap = (aes_key == K && aes_block == B) ? PT : (aes_block ^ aes_key);
            repeat (aes_lat) @(posedge clk);
            #1 aes_done = 1'b1; aes_result = aes_cap;
            @(posedge clk);
            #1 aes_done = 1'b0;
         end
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish (compared %0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push128(input logic [127:0] v);
      for (int i = 15; i >= 0; i--) fq.push_back(v[8*i +: 8]);
   endtask

   task automatic send_q();
      for (int i = 0; i < fq.size(); i++) begin
         rx_valid = 1'b1; rx_data = fq[i];
         step(1);
      end
      rx_valid = 1'b0;
      fq.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; step(2); rst = 1'b0; step(1);
   endtask

   task automatic wait_sd(input int base, input int budget, input string tag);
      for (int i = 0; i < budget && n_sd <= base; i++) step(1);
      chk(tag, 128'(n_sd > base), 128'd1);
   endtask

   task automatic chk_blk(input string tag, input int base, input logic [127:0] exp);
      logic [7:0] got;
      for (int i = 0; i < 16; i++) begin
         got = (base + i < txq.size()) ? txq[base + i] : 8'hxx;
         chk($sformatf("%s_b%0d", tag, i), got, exp[127 - 8*i -: 8]);
      end
   endtask

   int base, sd0, a0, r0, v0;
   logic [127:0] kv;

   initial begin
      rx_valid = 1'b0; rx_data = 8'h00;
      rst = 1'b1;
      step(3);
      chk("rst_outs", {rsa_start, aes_start, tx_valid, session_done, busy, err_overrun, err_timeout}, 0);
      chk("rst_blocks_done", blocks_done, 0);
      chk("rst_rsa_cipher", rsa_cipher, 0);
      chk("rst_aes_key", aes_key, 0);
      chk("rst_aes_block", aes_block, 0);
      chk("rst_tx_data", tx_data, 0);
      rst = 1'b0; step(1);

      // single block, known answer
      sd0 = n_sd; a0 = n_aes; r0 = n_rsa; base = txq.size();
      push128(K); fq.push_back(8'd1); push128(B); send_q();
      wait_sd(sd0, 400, "t1_done_to");
      step(2);
      chk("t1_sd_pulses", n_sd - sd0, 1);
      chk("t1_rsa_starts", n_rsa - r0, 1);
      chk("t1_aes_starts", n_aes - a0, 1);
      chk("t1_aes_key", aes_key, K);
      chk("t1_aes_block", aes_block, B);
      chk("t1_rsa_cipher", rsa_cipher, K);
      chk("t1_tx_count", txq.size() - base, 16);
      chk_blk("t1_tx", base, PT);
      chk("t1_blocks_done", blocks_done, 1);
      chk("t1_idle", {busy, err_overrun, err_timeout}, 0);

      // N=3, random tx stalls, block 2 streamed while block 1 is transmitted
      stall = 1'b1; sd0 = n_sd; a0 = n_aes; base = txq.size();
      push128(K2); fq.push_back(8'd3); push128(C0); send_q();
      for (int i = 0; i < 300 && !tx_valid; i++) step(1);
      chk("t3_tx_start_to", tx_valid, 1);
      push128(C1); send_q();
      for (int i = 0; i < 400 && (n_aes - a0) < 2; i++) step(1);
      chk("t3_aes2_to", 128'((n_aes - a0) >= 2), 1);
      push128(C2); send_q();
      wait_sd(sd0, 1000, "t3_done_to");
      stall = 1'b0; step(2);
      chk("t3_tx_count", txq.size() - base, 48);
      chk_blk("t3_blk0", base, C0 ^ K2);
      chk_blk("t3_blk1", base + 16, C1 ^ K2);
      chk_blk("t3_blk2", base + 32, C2 ^ K2);
      chk("t3_overrun", err_overrun, 0);
      chk("t3_blocks_done", blocks_done, 3);
      chk("t3_sd_pulses", n_sd - sd0, 1);

      // overrun: 33 block bytes back-to-back against a slow AES core
      do_reset();
      aes_lat = 500; sd0 = n_sd; base = txq.size();
      push128(K2); fq.push_back(8'd2); push128(C0); push128(C1); send_q();
      chk("t4_no_ovr_32", err_overrun, 0);
      fq.push_back(8'hEE); send_q();
      chk("t4_ovr_33", err_overrun, 1);
      wait_sd(sd0, 3000, "t4_done_to");
      step(2);
      chk("t4_tx_count", txq.size() - base, 32);
      chk_blk("t4_blk0", base, C0 ^ K2);
      chk_blk("t4_blk1", base + 16, C1 ^ K2);
      chk("t4_blocks_done", blocks_done, 2);
      chk("t4_ovr_sticky", err_overrun, 1);
      aes_lat = 5;

      // N=0
      do_reset();
      sd0 = n_sd; a0 = n_aes; r0 = n_rsa; v0 = n_txv;
      push128(K); fq.push_back(8'd0); send_q();
      wait_sd(sd0, 200, "t5_done_to");
      step(3);
      chk("t5_rsa_starts", n_rsa - r0, 1);
      chk("t5_aes_starts", n_aes - a0, 0);
      chk("t5_tx_valid", n_txv - v0, 0);
      chk("t5_sd_pulses", n_sd - sd0, 1);
      chk("t5_sd_lag", sd_cyc - rd_cyc, 1);
      chk("t5_blocks_done", blocks_done, 0);

      // timeout after 7 key bytes, then a good frame
      do_reset();
      sd0 = n_sd; base = txq.size(); kv = K;
      for (int i = 0; i < 7; i++) fq.push_back(kv[127 - 8*i -: 8]);
      send_q();
      step(TMO - 1);
      chk("t6_tmo_early", err_timeout, 0);
      chk("t6_busy_early", busy, 1);
      step(1);
      chk("t6_tmo", err_timeout, 1);
      chk("t6_busy", busy, 0);
      chk("t6_no_sd", n_sd - sd0, 0);
      push128(K); fq.push_back(8'd1); push128(B); send_q();
      wait_sd(sd0, 400, "t6_done_to");
      step(2);
      chk("t6_tx_count", txq.size() - base, 16);
      chk_blk("t6_tx", base, PT);
      chk("t6_blocks_done", blocks_done, 1);
      chk("t6_tmo_sticky", err_timeout, 1);

      // reset in S_AES, late aes_done
      do_reset();
      aes_lat = 40; sd0 = n_sd; a0 = n_aes; v0 = n_txv;
      push128(K); fq.push_back(8'd1); push128(B); send_q();
      for (int i = 0; i < 200 && n_aes == a0; i++) step(1);
      chk("t7_aes_to", 128'(n_aes > a0), 1);
      step(5);
      rst = 1'b1; step(1); rst = 1'b0;
      step(60);
      chk("t7_tx_valid", n_txv - v0, 0);
      chk("t7_no_sd", n_sd - sd0, 0);
      chk("t7_outs", {rsa_start, aes_start, tx_valid, session_done, busy, err_overrun, err_timeout}, 0);
      chk("t7_blocks_done", blocks_done, 0);
      chk("t7_aes_key", aes_key, 0);
      chk("t7_aes_block", aes_block, 0);
      chk("t7_rsa_cipher", rsa_cipher, 0);
      chk("t7_tx_data", tx_data, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
